sram_responder: RTL and testbench
=================================

# sram_responder

Clocked responder model of the 256K x 16 asynchronous SRAM on the board's SRAM pin bus. It is the device end of the protocol driven by the memory-stage SRAM controller: it takes address, byte masks, chip/output/write enables, and drives or samples the shared 16-bit data bus. It is used in system simulation and on-chip loopback benches in place of the physical chip, and adds access counters and a sticky protocol-error flag for verification.

## Interface
- ADDR_W, 18, address width; array depth 2^ADDR_W 16-bit words
- RD_LAT, 0, read latency in clk cycles (0 = asynchronous read, 1..3 = registered pipeline)
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- SRAM_DQ  inout  16  data bus; driven by this block only during reads
- SRAM_ADDR  in  ADDR_W  word address
- SRAM_UB_N  in  1  high-byte mask, active-low
- SRAM_LB_N  in  1  low-byte mask, active-low
- SRAM_WE_N  in  1  write enable, active-low
- SRAM_CE_N  in  1  chip enable, active-low
- SRAM_OE_N  in  1  output enable, active-low
- wr_count  out  32  writes committed since reset
- rd_count  out  32  read accesses since reset
- proto_err  out  1  sticky protocol error (only with SRAM_PROTO_CHECK_EN)

## Operation
- Cycle classes, evaluated on each posedge: write = CE_N=0 & WE_N=0; read = CE_N=0 & WE_N=1 & OE_N=0; idle otherwise. WE_N=0 overrides OE_N (OE_N tied low by controller is legal).
- Write: mem[SRAM_ADDR][7:0] <= SRAM_DQ[7:0] if LB_N=0; mem[..][15:8] <= SRAM_DQ[15:8] if UB_N=0. Both masks high: no array change, still counted.
- Read data: word from mem[addr]; bytes with mask high are driven as 8'h00.
- Drive enable: SRAM_DQ driven only when the output-stage read condition is true; else 16'hZZZZ. Never driven during write cycles.
- RD_LAT=0: output condition and data combinational from current pins; array read is combinational of SRAM_ADDR.
- RD_LAT=N>0: shift register of N stages holding {read_valid, addr, UB_N, LB_N}; array read at output stage from registered address; drive enable = last stage valid & current read condition.
- rd_count increments on an edge classed read when previous edge was not read or SRAM_ADDR differs from the previous edge's address (a held address counts once).
- wr_count increments on every edge classed write (held write over 2 edges counts 2).
- Counters saturate at 32'hFFFF_FFFF.
- rst: clears counters, pipeline valids, proto_err, last-address register. Array contents are NOT cleared (retained across reset, as the chip).

## Timing
- Reset values: wr_count=0, rd_count=0, proto_err=0, SRAM_DQ=Z for RD_LAT>0 (RD_LAT=0 follows pins combinationally).
- Write commits on the edge where write is sampled; readable by a read presented in the same cycle after that edge.
- Read, RD_LAT=0: address set after edge k -> valid data sampled by controller at edge k+1 (controller's two-word read over counter 0..2 works).
- Read, RD_LAT=N: address sampled at edge k -> data valid from edge k+N until the next edge.
- Same-address write and pipelined read in flight: read returns array value at the output stage (write-first).
- rst asserted mid-read: pipeline flushed, bus released to Z the cycle after the reset edge.

## Configuration
- SRAM_PROTO_CHECK_EN defined: proto_err set (sticky until rst) on any edge where: write with SRAM_DQ containing X/Z bits on an unmasked byte; WE_N, CE_N or OE_N is X/Z; or SRAM_ADDR >= 2^ADDR_W-used region is X/Z during a non-idle cycle. A $display reporting time, address and cause is issued on first set.
- Not defined: check logic absent, proto_err tied 0, fully synthesizable.

## Test plan
- Write 16'hBEEF to addr 18'h00010 (UB_N=LB_N=0), then read it, RD_LAT=0 -> DQ=16'hBEEF at next edge; wr_count=1, rd_count=1.
- Controller 32-bit write of 32'h1234_5678 at byte addr 0x40 then read -> words 18'h20=16'h5678, 18'h21=16'h1234; readDate=64'h0000_0000_1234_5678.
- Byte write 16'hAA55 with UB_N=1 over word 16'hFFFF -> read returns 16'hFF55; read with LB_N=1 returns 16'hFF00.
- RD_LAT=2, read addr 5 (holding 16'h0A0A) at edge k -> DQ Z until edge k+2, then 16'h0A0A; held address 4 cycles -> rd_count=1.
- rst pulse mid-read after 3 writes -> counters 0, DQ Z next cycle; prior written data still reads back unchanged.
- With SRAM_PROTO_CHECK_EN, write with SRAM_DQ=16'hzzzz -> proto_err=1, stays 1 through idle cycles, cleared only by rst.

Source files
------------

// File: rtl/sram_responder.sv
// Clocked device-side model of the 256K x 16 async SRAM with access counters.
// Optional protocol checker enabled by defining SRAM_PROTO_CHECK_EN.
module sram_responder #(
    parameter int ADDR_W = 18,
    parameter int RD_LAT = 0
) (
    input  logic              clk,
    input  logic              rst,
    inout  wire  [15:0]       SRAM_DQ,
    input  logic [ADDR_W-1:0] SRAM_ADDR,
    input  logic              SRAM_UB_N,
    input  logic              SRAM_LB_N,
    input  logic              SRAM_WE_N,
    input  logic              SRAM_CE_N,
    input  logic              SRAM_OE_N,
    output logic [31:0]       wr_count,
    output logic [31:0]       rd_count,
    output logic              proto_err
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [15:0]       mem [0:DEPTH-1];
    logic              write_cyc;
    logic              read_cyc;
    logic              last_read;
    logic [ADDR_W-1:0] last_addr;
    logic              out_valid;
    logic [ADDR_W-1:0] out_addr;
    logic              out_ub_n;
    logic              out_lb_n;
    logic [15:0]       rd_word;
    logic [15:0]       dq_out;

    // WE_N low wins over OE_N so a controller that ties OE_N low can still write
    assign write_cyc = !SRAM_CE_N && !SRAM_WE_N;
    assign read_cyc  = !SRAM_CE_N &&  SRAM_WE_N && !SRAM_OE_N;

    // Array is deliberately not reset: contents survive rst like the real chip
    always_ff @(posedge clk) begin
        if (write_cyc) begin
            if (!SRAM_LB_N) mem[SRAM_ADDR][7:0]  <= SRAM_DQ[7:0];
            if (!SRAM_UB_N) mem[SRAM_ADDR][15:8] <= SRAM_DQ[15:8];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_count  <= '0;
            rd_count  <= '0;
            last_read <= 1'b0;
            last_addr <= '0;
        end else begin
            if (write_cyc && wr_count != 32'hFFFF_FFFF)
                wr_count <= wr_count + 32'd1;
            if (read_cyc && (!last_read || SRAM_ADDR != last_addr) && rd_count != 32'hFFFF_FFFF)
                rd_count <= rd_count + 32'd1;
            last_read <= read_cyc;
            last_addr <= SRAM_ADDR;
        end
    end

    generate
        if (RD_LAT == 0) begin : g_async
            assign out_valid = read_cyc;
            assign out_addr  = SRAM_ADDR;
            assign out_ub_n  = SRAM_UB_N;
            assign out_lb_n  = SRAM_LB_N;
        end else begin : g_pipe
            logic [RD_LAT-1:0] pipe_valid;
            logic [RD_LAT-1:0] pipe_ub_n;
            logic [RD_LAT-1:0] pipe_lb_n;
            logic [ADDR_W-1:0] pipe_addr [RD_LAT];

            always_ff @(posedge clk) begin
                if (rst) begin
                    pipe_valid <= '0;
                end else begin
                    pipe_valid[0] <= read_cyc;
                    for (int i = 1; i < RD_LAT; i++)
                        pipe_valid[i] <= pipe_valid[i-1];
                end
                pipe_addr[0] <= SRAM_ADDR;
                pipe_ub_n[0] <= SRAM_UB_N;
                pipe_lb_n[0] <= SRAM_LB_N;
                for (int i = 1; i < RD_LAT; i++) begin
                    pipe_addr[i] <= pipe_addr[i-1];
                    pipe_ub_n[i] <= pipe_ub_n[i-1];
                    pipe_lb_n[i] <= pipe_lb_n[i-1];
                end
            end

            // Reading the array at the output stage makes in-flight reads see later writes
            assign out_valid = pipe_valid[RD_LAT-1] && read_cyc;
            assign out_addr  = pipe_addr[RD_LAT-1];
            assign out_ub_n  = pipe_ub_n[RD_LAT-1];
            assign out_lb_n  = pipe_lb_n[RD_LAT-1];
        end
    endgenerate

    assign rd_word = mem[out_addr];
    assign dq_out  = {out_ub_n ? 8'h00 : rd_word[15:8], out_lb_n ? 8'h00 : rd_word[7:0]};
    assign SRAM_DQ = out_valid ? dq_out : 16'hzzzz;

`ifdef SRAM_PROTO_CHECK_EN
    logic err_ctrl;
    logic err_data;
    logic err_addr;

    assign err_ctrl = $isunknown({SRAM_WE_N, SRAM_CE_N, SRAM_OE_N});
    assign err_data = write_cyc && ((!SRAM_LB_N && $isunknown(SRAM_DQ[7:0])) ||
                                    (!SRAM_UB_N && $isunknown(SRAM_DQ[15:8])));
    assign err_addr = (write_cyc || read_cyc) && $isunknown(SRAM_ADDR);

    always_ff @(posedge clk) begin
        if (rst) begin
            proto_err <= 1'b0;
        end else if (!proto_err && (err_ctrl || err_data || err_addr)) begin
            proto_err <= 1'b1;
            $display("sram_responder: protocol error at %0t addr=%h cause=%s", $time, SRAM_ADDR,
                     err_ctrl ? "control X/Z" : (err_data ? "write data X/Z" : "address X/Z"));
        end
    end
`else
    assign proto_err = 1'b0;
`endif

endmodule

// File: tb/tb_sram_responder.sv
// Directed bench for sram_responder: an async-read instance (RD_LAT=0) and a
// two-stage pipelined instance (RD_LAT=2) sharing address/control pins.
module tb_sram_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic [17:0] addr;
    logic        ub_n, lb_n, we_n, oe_n;
    logic        ce0_n, ce2_n;
    logic        tb_drv;
    logic [15:0] tb_val;
    wire  [15:0] dq0;
    wire  [15:0] dq2;
    logic [31:0] wr0, rd0, wr2, rd2;
    logic        perr0, perr2;
    logic [15:0] lo_word, hi_word;

    int assertCount = 0;
    int failCount   = 0;

    always #5 clk = ~clk;

    // Pull-ups make a released bus read back as 16'hFFFF
    for (genvar i = 0; i < 16; i++) begin : g_pu
        pullup (dq0[i]);
        pullup (dq2[i]);
    end

    assign dq0 = tb_drv ? tb_val : 16'hzzzz;
    assign dq2 = tb_drv ? tb_val : 16'hzzzz;

    sram_responder #(.ADDR_W(18), .RD_LAT(0)) u0 (
        .clk(clk), .rst(rst), .SRAM_DQ(dq0), .SRAM_ADDR(addr),
        .SRAM_UB_N(ub_n), .SRAM_LB_N(lb_n), .SRAM_WE_N(we_n),
        .SRAM_CE_N(ce0_n), .SRAM_OE_N(oe_n),
        .wr_count(wr0), .rd_count(rd0), .proto_err(perr0)
    );

    sram_responder #(.ADDR_W(18), .RD_LAT(2)) u2 (
        .clk(clk), .rst(rst), .SRAM_DQ(dq2), .SRAM_ADDR(addr),
        .SRAM_UB_N(ub_n), .SRAM_LB_N(lb_n), .SRAM_WE_N(we_n),
        .SRAM_CE_N(ce2_n), .SRAM_OE_N(oe_n),
        .wr_count(wr2), .rd_count(rd2), .proto_err(perr2)
    );

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        assertCount++;
        if (obs !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic c0, input logic c2, input logic we, input logic oe,
                                 input logic ub, input logic lb, input logic [17:0] a,
                                 input logic drv, input logic [15:0] val);
        ce0_n  = c0;
        ce2_n  = c2;
        we_n   = we;
        oe_n   = oe;
        ub_n   = ub;
        lb_n   = lb;
        addr   = a;
        tb_drv = drv;
        tb_val = val;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        applyStimulus(1, 1, 1, 1, 0, 0, 18'h0, 0, 16'h0000);
    endtask

    initial begin
        rst = 1'b1;
        // Read pins active on the pipelined chip during reset: bus must stay released
        applyStimulus(1, 0, 1, 0, 0, 0, 18'h0, 0, 16'h0000);
        tick();
        tick();
        checkOutput("reset_dq2_released", 64'(dq2), 64'hFFFF);
        checkOutput("reset_wr0", 64'(wr0), 64'd0);
        checkOutput("reset_rd0", 64'(rd0), 64'd0);
        checkOutput("reset_wr2", 64'(wr2), 64'd0);
        checkOutput("reset_rd2", 64'(rd2), 64'd0);
        checkOutput("reset_proto", 64'(perr0), 64'd0);
        idle();
        rst = 1'b0;
        tick();

        $display("[TB] async write/read BEEF");
        applyStimulus(0, 1, 0, 1, 0, 0, 18'h00010, 1, 16'hBEEF);
        tick();
        applyStimulus(0, 1, 1, 0, 0, 0, 18'h00010, 0, 16'h0000);
        #1;
        checkOutput("rd0_beef", 64'(dq0), 64'hBEEF);
        tick();
        idle();
        checkOutput("wr0_after_beef", 64'(wr0), 64'd1);
        checkOutput("rd0_after_beef", 64'(rd0), 64'd1);

        $display("[TB] 32-bit write at byte addr 0x40");
        applyStimulus(0, 1, 0, 1, 0, 0, 18'h00020, 1, 16'h5678);
        tick();
        applyStimulus(0, 1, 0, 1, 0, 0, 18'h00021, 1, 16'h1234);
        tick();
        applyStimulus(0, 1, 1, 0, 0, 0, 18'h00020, 0, 16'h0000);
        #1;
        lo_word = dq0;
        tick();
        applyStimulus(0, 1, 1, 0, 0, 0, 18'h00021, 0, 16'h0000);
        #1;
        hi_word = dq0;
        tick();
        idle();
        checkOutput("read_date_64", {32'h0, hi_word, lo_word}, 64'h0000_0000_1234_5678);

        $display("[TB] byte masks");
        applyStimulus(0, 1, 0, 1, 0, 0, 18'h00030, 1, 16'hFFFF);
        tick();
        applyStimulus(0, 1, 0, 1, 1, 0, 18'h00030, 1, 16'hAA55);
        tick();
        applyStimulus(0, 1, 1, 0, 0, 0, 18'h00030, 0, 16'h0000);
        #1;
        checkOutput("byte_write_lo", 64'(dq0), 64'hFF55);
        lb_n = 1'b1;
        #1;
        checkOutput("read_lb_masked", 64'(dq0), 64'hFF00);
        ub_n = 1'b1;
        lb_n = 1'b0;
        #1;
        checkOutput("read_ub_masked", 64'(dq0), 64'h0055);
        tick();
        applyStimulus(0, 1, 0, 1, 1, 1, 18'h00030, 1, 16'h1234);
        tick();
        applyStimulus(0, 1, 0, 1, 0, 0, 18'h00031, 1, 16'h4321);
        tick();
        tick();
        applyStimulus(0, 1, 1, 0, 0, 0, 18'h00030, 0, 16'h0000);
        #1;
        checkOutput("both_masks_no_change", 64'(dq0), 64'hFF55);
        tick();
        applyStimulus(0, 1, 1, 0, 0, 0, 18'h00031, 0, 16'h0000);
        #1;
        checkOutput("held_write_data", 64'(dq0), 64'h4321);
        tick();
        idle();
        checkOutput("wr0_masks_held", 64'(wr0), 64'd8);
        checkOutput("rd0_addr_change", 64'(rd0), 64'd6);
        tick();
        applyStimulus(0, 1, 1, 0, 0, 0, 18'h00031, 0, 16'h0000);
        tick();
        idle();
        checkOutput("rd0_reread_after_idle", 64'(rd0), 64'd7);

        $display("[TB] pipelined read RD_LAT=2");
        applyStimulus(1, 0, 0, 1, 0, 0, 18'h00005, 1, 16'h0A0A);
        tick();
        idle();
        tick();
        applyStimulus(1, 0, 1, 0, 0, 0, 18'h00005, 0, 16'h0000);
        tick();
        checkOutput("lat2_z_after_k", 64'(dq2), 64'hFFFF);
        tick();
        checkOutput("lat2_data_at_k2", 64'(dq2), 64'h0A0A);
        tick();
        checkOutput("lat2_data_held", 64'(dq2), 64'h0A0A);
        tick();
        idle();
        checkOutput("rd2_held_once", 64'(rd2), 64'd1);

        $display("[TB] write-first with read in flight");
        applyStimulus(1, 0, 0, 1, 0, 0, 18'h00007, 1, 16'h1111);
        tick();
        applyStimulus(1, 0, 1, 0, 0, 0, 18'h00007, 0, 16'h0000);
        tick();
        applyStimulus(1, 0, 0, 1, 0, 0, 18'h00007, 1, 16'h2222);
        tick();
        applyStimulus(1, 0, 1, 0, 0, 0, 18'h00007, 0, 16'h0000);
        #1;
        checkOutput("write_first", 64'(dq2), 64'h2222);
        tick();
        idle();
        checkOutput("wr2_before_rst", 64'(wr2), 64'd3);
        checkOutput("rd2_before_rst", 64'(rd2), 64'd3);

        $display("[TB] reset mid-read");
        applyStimulus(1, 0, 1, 0, 0, 0, 18'h00005, 0, 16'h0000);
        tick();
        tick();
        checkOutput("pre_rst_data", 64'(dq2), 64'h0A0A);
        rst = 1'b1;
        tick();
        checkOutput("rst_dq2_released", 64'(dq2), 64'hFFFF);
        checkOutput("rst_wr2", 64'(wr2), 64'd0);
        checkOutput("rst_rd2", 64'(rd2), 64'd0);
        checkOutput("rst_wr0", 64'(wr0), 64'd0);
        rst = 1'b0;
        tick();
        tick();
        checkOutput("retained_after_rst", 64'(dq2), 64'h0A0A);
        tick();
        idle();
        checkOutput("rd2_after_rst", 64'(rd2), 64'd1);

`ifdef SRAM_PROTO_CHECK_EN
        $display("[TB] protocol checker");
        applyStimulus(0, 1, 0, 1, 0, 0, 18'h00100, 1, 16'hzzzz);
        tick();
        idle();
        tick();
        tick();
        checkOutput("proto_sticky", 64'(perr0), 64'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("proto_cleared", 64'(perr0), 64'd0);
`else
        checkOutput("proto_tied_low", 64'(perr0 | perr2), 64'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
